// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C bit-level sequencer: command codes, FSM states
// and the per-phase open-drain drive table.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    PH_D = 3'd4
  } state_t;

  // Line levels are listed A..D from MSB to LSB; result is {scl_oe, sda_oe}.
  function automatic logic [1:0] phase_oe(cmd_t cmd, state_t ph, logic din);
    logic [3:0] scl_lvl;
    logic [3:0] sda_lvl;
    int         idx;
    case (cmd)
      CMD_START: begin scl_lvl = 4'b1110; sda_lvl = 4'b1100;     end
      CMD_STOP:  begin scl_lvl = 4'b0111; sda_lvl = 4'b0001;     end
      CMD_WRITE: begin scl_lvl = 4'b0110; sda_lvl = {4{din}};    end
      default:   begin scl_lvl = 4'b0110; sda_lvl = 4'b1111;     end
    endcase
    case (ph)
      PH_A:    idx = 3;
      PH_B:    idx = 2;
      PH_C:    idx = 1;
      default: idx = 0;
    endcase
    return {~scl_lvl[idx], ~sda_lvl[idx]};
  endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-bit pacing timer: Start restarts the count, Stop freezes it, Out
// pulses on the last of every Ticks running cycles.
module i2c_bit_timer #(
  parameter int SIZE = 8
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Start,
  input  logic            Stop,
  input  logic [SIZE-1:0] Ticks,
  output logic            Out
);

  logic [SIZE-1:0] cnt;
  logic            wrap;

  assign wrap = (cnt == Ticks - SIZE'(1));
  assign Out  = !Start && !Stop && wrap;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      cnt <= '0;
    else if (Start)
      cnt <= '0;
    else if (!Stop)
      cnt <= wrap ? '0 : cnt + SIZE'(1);
  end

endmodule

// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master sequencer: runs one START/STOP/WRITE/READ as four timed
// phases. Define I2C_CLK_STRETCH_EN to honour slave clock stretching.
module i2c_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic [SIZE-1:0] ClkDiv,
  input  logic [1:0]      Cmd,
  input  logic            CmdValid,
  output logic            CmdReady,
  input  logic            Din,
  output logic            Dout,
  output logic            Done,
  output logic            ArbLost,
  output logic            Busy,
  input  logic            SclIn,
  input  logic            SdaIn,
  output logic            SclOe,
  output logic            SdaOe
);

  state_t     state;
  cmd_t       cmd_q;
  logic       din_q;
  logic [1:0] sda_sync;
  logic       sda_s;
  logic       accept;
  logic       tick;
  logic       stretch;
  logic       arb_hit;
  logic       mid_phase;

  assign sda_s     = sda_sync[1];
  assign CmdReady  = (state == IDLE) && (ClkDiv != '0);
  assign Busy      = (state != IDLE);
  assign accept    = CmdValid && CmdReady;
  assign mid_phase = (state == PH_B) || (state == PH_C);
  assign arb_hit   = mid_phase && (cmd_q == CMD_WRITE) && din_q && !sda_s;

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] scl_sync;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) scl_sync <= 2'b11;
    else        scl_sync <= {scl_sync[0], SclIn};
  end
  assign stretch = mid_phase && !scl_sync[1];
`else
  logic unused_scl;
  assign unused_scl = SclIn;
  assign stretch    = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) sda_sync <= 2'b11;
    else        sda_sync <= {sda_sync[0], SdaIn};
  end

  i2c_bit_timer #(.SIZE(SIZE)) u_timer (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (accept),
    .Stop  (!Busy || stretch),
    .Ticks (ClkDiv),
    .Out   (tick)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      cmd_q   <= CMD_START;
      din_q   <= 1'b0;
      SclOe   <= 1'b0;
      SdaOe   <= 1'b0;
      Done    <= 1'b0;
      ArbLost <= 1'b0;
      Dout    <= 1'b0;
    end else begin
      Done    <= 1'b0;
      ArbLost <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          cmd_q          <= cmd_t'(Cmd);
          din_q          <= Din;
          state          <= PH_A;
          {SclOe, SdaOe} <= phase_oe(cmd_t'(Cmd), PH_A, Din);
        end
      end else if (arb_hit) begin
        // Another master owns SDA: back off completely, no Done.
        ArbLost        <= 1'b1;
        SclOe          <= 1'b0;
        SdaOe          <= 1'b0;
        state          <= IDLE;
      end else if (tick) begin
        if (state == PH_C && cmd_q == CMD_READ)
          Dout <= sda_s;
        if (state == PH_D) begin
          state <= IDLE;
          Done  <= 1'b1;
        end else begin
          state          <= state_t'(state + 3'd1);
          {SclOe, SdaOe} <= phase_oe(cmd_q, state_t'(state + 3'd1), din_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for i2c_bit_ctrl: per-cycle line traces against phase tables,
// completion timing, READ sampling, arbitration loss, stretching and reset.
module tb_i2c_bit_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] ClkDiv;
  logic [1:0] Cmd;
  logic       CmdValid, Din;
  logic       CmdReady, Dout, Done, ArbLost, Busy;
  logic       SclIn, SdaIn, SclOe, SdaOe;
  logic       scl_hold, sda_pull;

`ifdef I2C_CLK_STRETCH_EN
  localparam int SX = 2;
`else
  localparam int SX = 0;
`endif

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          done_at, arb_at, d0;
  logic        dout_at;
  logic [31:0] scl_tr, sda_tr;

  // Open-drain bus: a line is low if anyone pulls it.
  assign SclIn = !SclOe && !scl_hold;
  assign SdaIn = !SdaOe && !sda_pull;

  i2c_bit_ctrl #(.SIZE(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ClkDiv(ClkDiv), .Cmd(Cmd), .CmdValid(CmdValid),
    .CmdReady(CmdReady), .Din(Din), .Dout(Dout), .Done(Done), .ArbLost(ArbLost),
    .Busy(Busy), .SclIn(SclIn), .SdaIn(SdaIn), .SclOe(SclOe), .SdaOe(SdaOe)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (Done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle oe pattern from per-phase values (ph[0]=A); PH_B may be longer.
  function automatic logic [31:0] expand(logic [3:0] ph, int n, int xb);
    logic [31:0] v = '0;
    int k = 0;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < n + ((p == 1) ? xb : 0); i++) begin
        v[k] = ph[p];
        k++;
      end
    return v;
  endfunction

  task automatic send(input logic [1:0] c, input logic d);
    @(negedge Clk);
    chk("ready_before_send", CmdReady, 1'b1);
    Cmd = c; Din = d; CmdValid = 1'b1;
    @(posedge Clk); #1;
    CmdValid = 1'b0;
  endtask

  // Trace oe per cycle after PH_A entry until Done/ArbLost or 64 cycles.
  task automatic run(input int hon, input int hoff, input int pon);
    scl_tr = '0; sda_tr = '0; done_at = -1; arb_at = -1; dout_at = 1'bx;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) begin @(posedge Clk); #1; end
      if (k == hoff) scl_hold = 1'b0;
      @(negedge Clk);
      if (Done) begin done_at = k; dout_at = Dout; break; end
      if (ArbLost) begin arb_at = k; break; end
      if (k < 32) begin scl_tr[k] = SclOe; sda_tr[k] = SdaOe; end
      if (k == hon) scl_hold = 1'b1;
      if (k == pon) sda_pull = 1'b1;
    end
  endtask

  initial begin
    Rst_n = 1'b0; ClkDiv = 8'd4; Cmd = 2'b00; CmdValid = 1'b0; Din = 1'b0;
    scl_hold = 1'b0; sda_pull = 1'b0;
    #23;
    chk("rst_scl_oe", SclOe, 1'b0);
    chk("rst_sda_oe", SdaOe, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done_arb_dout", {Done, ArbLost, Dout}, 3'b000);
    @(negedge Clk); Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk("idle_ready", CmdReady, 1'b1);

    // ClkDiv==0 blocks acceptance.
    ClkDiv = 8'd0; #1;
    chk("div0_ready", CmdReady, 1'b0);
    Cmd = 2'b00; CmdValid = 1'b1;
    repeat (3) @(negedge Clk);
    chk("div0_busy", Busy, 1'b0);
    CmdValid = 1'b0; ClkDiv = 8'd4;

    // START: SDA falls in PH_C while SCL still released, SCL low in PH_D.
    send(2'b00, 1'b0);
    run(-1, -1, -1);
    chk("start_done_at", done_at, 16);
    chk("start_scl", scl_tr, expand(4'b1000, 4, 0));
    chk("start_sda", sda_tr, expand(4'b1100, 4, 0));
    @(negedge Clk);
    chk("done_one_cycle", Done, 1'b0);

    // WRITE 0: SCL low 4, released 8, low 4; SDA held low.
    send(2'b10, 1'b0);
    run(-1, -1, -1);
    chk("wr0_done_at", done_at, 16 + SX);
    chk("wr0_scl", scl_tr, expand(4'b1001, 4, SX));
    chk("wr0_sda", sda_tr, expand(4'b1111, 4, SX));

    // READ with SDA high, then low, ClkDiv=3.
    @(negedge Clk); ClkDiv = 8'd3;
    send(2'b11, 1'b0);
    run(-1, -1, -1);
    chk("rd1_done_at", done_at, 12 + SX);
    chk("rd1_dout", dout_at, 1'b1);
    chk("rd1_scl", scl_tr, expand(4'b1001, 3, SX));
    chk("rd1_sda", sda_tr, 32'h0);
    sda_pull = 1'b1;
    send(2'b11, 1'b0);
    run(-1, -1, -1);
    chk("rd0_done_at", done_at, 12 + SX);
    chk("rd0_dout", dout_at, 1'b0);
    chk("rd0_sda", sda_tr, 32'h0);
    sda_pull = 1'b0;

    // Arbitration: SDA pulled low at PH_B while sending 1.
    @(negedge Clk); ClkDiv = 8'd4;
    d0 = done_cnt;
    send(2'b10, 1'b1);
    run(-1, -1, 4);
    chk("arb_at", arb_at, 7);
    chk("arb_no_done_at", done_at, -1);
    chk("arb_lines", {SclOe, SdaOe}, 2'b00);
    chk("arb_ready", CmdReady, 1'b1);
    sda_pull = 1'b0;
    repeat (4) @(negedge Clk);
    chk("arb_no_done", done_cnt, d0);
    chk("arb_pulse", ArbLost, 1'b0);

    // Slave holds SCL low for the first 10 cycles of PH_B.
    send(2'b10, 1'b0);
    run(3, 14, -1);
`ifdef I2C_CLK_STRETCH_EN
    chk("stretch_done_at", done_at, 28);
`else
    chk("stretch_done_at", done_at, 16);
`endif
    scl_hold = 1'b0;

    // Reset in PH_C releases lines at once and discards the command.
    send(2'b10, 1'b0);
    repeat (11) @(negedge Clk);
    chk("pre_rst_busy", Busy, 1'b1);
    d0 = done_cnt;
    Rst_n = 1'b0; #1;
    chk("mid_rst_lines", {SclOe, SdaOe}, 2'b00);
    chk("mid_rst_busy", Busy, 1'b0);
    @(negedge Clk); Rst_n = 1'b1;
    repeat (20) @(negedge Clk);
    chk("post_rst_no_done", done_cnt, d0);
    send(2'b01, 1'b0);
    run(-1, -1, -1);
    chk("stop_done_at", done_at, 16 + SX);
    chk("stop_scl", scl_tr, expand(4'b0001, 4, SX));
    chk("stop_sda", sda_tr, expand(4'b0111, 4, SX));
    @(negedge Clk);
    chk("stop_released", {SclOe, SdaOe}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_bit_ctrl.md
Name: i2c_bit_ctrl

Overview:
- Bit-level I2C master sequencer. Executes one START, STOP, WRITE-bit or READ-bit command at a time.
- Drives SCL/SDA as open-drain pull-low enables.
- Instantiates i2c_bit_timer to pace each bit as four quarter-period phases.
- Sits between the byte-level I2C controller (command source) and the pad open-drain buffers.

Parameters:
- SIZE, 8: width of the ClkDiv and i2c_bit_timer Ticks buses.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- ClkDiv  in  SIZE  quarter-bit period in Clk cycles; drives timer Ticks; must be stable while Busy.
- Cmd  in  2  command code (package encoding).
- CmdValid  in  1  command request.
- CmdReady  out  1  block can accept a command.
- Din  in  1  bit to transmit for WRITE.
- Dout  out  1  bit sampled by READ; valid when Done=1, held until next READ completes.
- Done  out  1  one-cycle pulse when a command completes.
- ArbLost  out  1  one-cycle pulse on arbitration loss.
- Busy  out  1  command in progress.
- SclIn  in  1  SCL pad level.
- SdaIn  in  1  SDA pad level.
- SclOe  out  1  1 = pull SCL low.
- SdaOe  out  1  1 = pull SDA low.

Behaviour:
- Clock and reset: single clock Clk; asynchronous active-low reset Rst_n.
- Reset values: SclOe=0, SdaOe=0 (both lines released), Busy=0, Done=0, ArbLost=0, Dout=0, state=IDLE.
- Reset mid-command: lines released immediately (asynchronously) and the command is discarded.
- Input synchronisation: SclIn and SdaIn pass through 2-flop synchronisers; all internal use is on the synchronised copies.
- CmdReady = (state==IDLE) && (ClkDiv!=0).
  - ClkDiv==0: no command is ever accepted.
- Accept: CmdValid && CmdReady at a rising edge.
  - Latch Cmd and Din.
  - Assert timer Start for that one cycle.
  - Enter PH_A on the next edge; Busy=1.
- Phase timing:
  - Timer Stop=0 while running; each timer Out pulse ends the current phase.
  - Each phase lasts ClkDiv cycles.
  - Phase sequence PH_A -> PH_B -> PH_C -> PH_D -> IDLE.
- Line drive: SclOe/SdaOe are registered and take a phase's values on the edge entering that phase. Values are SCL/SDA levels per phase A,B,C,D; 0 = pulled low, 1 = released.
  - START: SCL 1,1,1,0; SDA 1,1,0,0.
  - STOP: SCL 0,1,1,1; SDA 0,0,0,1.
  - WRITE: SCL 0,1,1,0; SDA = Din in all phases.
  - READ: SCL 0,1,1,0; SDA released in all phases. Dout is loaded from synchronised SdaIn on the Out pulse that ends PH_C.
- Completion: on the Out pulse ending PH_D, go to IDLE, pulse Done, set Busy=0.
  - The next command can be accepted on the cycle after Done at the earliest.
  - CmdValid asserted while Busy is ignored (CmdReady=0).
- Arbitration (WRITE with Din=1 only): if synchronised SdaIn==0 during PH_B or PH_C:
  - pulse ArbLost;
  - release both lines;
  - go to IDLE without Done.
- Final lines after each command: START leaves SCL low; STOP leaves both lines released.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined: in PH_B and PH_C, while synchronised SclIn==0 (slave stretching), timer Stop=1. The count holds, the phase does not advance and the line drive is unchanged. The phase ends ClkDiv running cycles after the stretch releases.
- Undefined: SclIn is ignored (port kept) and timer Stop is tied 0 while Busy.

Decomposition:
- Package i2c_pkg holds:
  - CMD_START=2'b00, CMD_STOP=2'b01, CMD_WRITE=2'b10, CMD_READ=2'b11;
  - state encodings IDLE, PH_A, PH_B, PH_C, PH_D.
- Sub-module: the existing i2c_bit_timer, instantiated as #(.SIZE(SIZE)) with Ticks=ClkDiv.
- Synchronisers stay inline.

Test Plan:
- Reset with ClkDiv=4, idle -> SclOe=0, SdaOe=0, CmdReady=1, Busy=0; with ClkDiv=0 -> CmdReady=0 and CmdValid is ignored.
- START then WRITE Din=0, ClkDiv=4 -> SDA falls while SCL high; SCL low 4 cycles, released 8, low 4; SdaOe=1 throughout the write. Each Done pulse comes 16 cycles after PH_A entry.
- READ with SdaIn held 1 (then a second READ with SdaIn 0), ClkDiv=3 -> Dout=1 then Dout=0 at the respective Done; SdaOe=0 during both.
- WRITE Din=1 with SdaIn forced 0 during PH_B -> ArbLost pulses within 3 cycles, both lines released, no Done, CmdReady=1 afterwards.
- Stretch with I2C_CLK_STRETCH_EN defined, ClkDiv=4 -> hold SclIn=0 for 10 cycles at the start of PH_B; PH_B lasts 10+2+4 cycles. Without the macro, PH_B lasts 4 cycles.
- Rst_n pulsed low mid-WRITE (PH_C) -> SclOe/SdaOe=0 immediately; after release, state IDLE, no Done, and a new STOP completes normally.
